// File: rtl/soc_bus_bridge.sv
// ---------------------------------------------------------------------------
// soc_bus_bridge
//
// Data-side bridge between the single-cycle core's data port and the board.
// Every access is decoded to either DRAM or the 4 KiB I/O page at
// 0xFFFFF000-0xFFFFFFFF. The I/O page holds the 7-segment digit register,
// a free-running timer, the LED register and the synchronised switches.
// Load data returns combinationally so the core can finish a load in the
// same cycle it issues it.
//
// I/O register map (byte offsets inside the page, address bits [1:0] ignored):
//   0x000 SEG    RW  eight hex nibbles, nibble k shown on digit k
//   0x020 TIMER  RW  32-bit counter, +1 every TIMER_DIV cycles
//   0x060 LED    RW  bits [23:0], upper byte reads as zero
//   0x070 SW     RO  {8'h0, synchronised switches}
//   0x078 BTN    RO  {27'h0, debounced buttons} (only with the macro below)
//   anything else reads zero and ignores writes
//
// Optional feature macro: SOC_BUS_BRIDGE_BTN_EN
//   When defined, adds btn_in[4:0] with a 2-flop synchroniser and a
//   per-bit debouncer (SCAN_DIV stable cycles) readable at offset 0x078.
//
// Ports:
//   cpu_clk     in   sole clock, rising edge
//   cpu_rst     in   asynchronous active-low reset
//   cpu_addr    in   byte address from the core (ALU result)
//   cpu_wdata   in   store data from the core (rs2)
//   cpu_we      in   store strobe from the core
//   cpu_rdata   out  load data to the core (combinational)
//   dram_addr   out  DRAM word address, cpu_addr[ADDR_W+1:2]
//   dram_wdata  out  DRAM write data, cpu_wdata
//   dram_we     out  DRAM write enable, stores outside the I/O page only
//   dram_rdata  in   DRAM read data
//   sw_in       in   raw board switches (asynchronous)
//   btn_in      in   raw buttons, active-high (macro builds only)
//   led_out     out  LED drive, 1 = lit (registered)
//   seg_an      out  digit enables, active-low, one digit at a time (registered)
//   seg_cx      out  segments {dp,g,f,e,d,c,b,a}, active-low (registered)
// ---------------------------------------------------------------------------
module soc_bus_bridge #(
    parameter int ADDR_W    = 14,
    parameter int SCAN_DIV  = 20000,
    parameter int TIMER_DIV = 1000
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_we,
    output logic [31:0]       cpu_rdata,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [31:0]       dram_wdata,
    output logic              dram_we,
    input  logic [31:0]       dram_rdata,
    input  logic [23:0]       sw_in,
`ifdef SOC_BUS_BRIDGE_BTN_EN
    input  logic [4:0]        btn_in,
`endif
    output logic [23:0]       led_out,
    output logic [7:0]        seg_an,
    output logic [7:0]        seg_cx
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [19:0] IO_PAGE   = 20'hFFFFF;

    // Word offsets (cpu_addr[11:2]) of the mapped registers.
    localparam logic [9:0]  OFF_SEG   = 10'h000;  // byte 0x000
    localparam logic [9:0]  OFF_TIMER = 10'h008;  // byte 0x020
    localparam logic [9:0]  OFF_LED   = 10'h018;  // byte 0x060
    localparam logic [9:0]  OFF_SW    = 10'h01C;  // byte 0x070
`ifdef SOC_BUS_BRIDGE_BTN_EN
    localparam logic [9:0]  OFF_BTN   = 10'h01E;  // byte 0x078
`endif

    // TIMER_DIV may be 1, in which case the prescaler is a constant zero.
    localparam int                TPRE_W   = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [TPRE_W-1:0] TPRE_MAX = TPRE_W'(TIMER_DIV - 1);
    localparam int                SPRE_W   = $clog2(SCAN_DIV);
    localparam logic [SPRE_W-1:0] SPRE_MAX = SPRE_W'(SCAN_DIV - 1);

    // Scan position: which of the eight digits is currently lit.
    typedef enum logic [2:0] {
        DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7
    } digit_t;

    // Active-low hex-to-segment decode, dp (bit 7) always off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] seg;
        case (hex)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0]       r_seg;
    logic [31:0]       r_timer;
    logic [TPRE_W-1:0] r_tpre;
    logic [23:0]       r_led;
    logic [23:0]       r_sw_s1;
    logic [23:0]       r_sw_s2;
    logic [SPRE_W-1:0] r_spre;
    digit_t            r_digit;
    logic [7:0]        r_an;
    logic [7:0]        r_cx;

`ifdef SOC_BUS_BRIDGE_BTN_EN
    logic [4:0]        r_btn_s1;
    logic [4:0]        r_btn_s2;
    logic [4:0]        r_btn_db;
    logic [SPRE_W-1:0] r_btn_cnt [5];
`endif

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic       w_io_sel;
    logic [9:0] w_off;
    logic       w_io_we;
    logic       w_wr_seg;
    logic       w_wr_timer;
    logic       w_wr_led;
    logic       w_unused_addr_lsb;

    assign w_io_sel   = (cpu_addr[31:12] == IO_PAGE);
    assign w_off      = cpu_addr[11:2];
    assign w_io_we    = cpu_we & w_io_sel;
    assign w_wr_seg   = w_io_we & (w_off == OFF_SEG);
    assign w_wr_timer = w_io_we & (w_off == OFF_TIMER);
    assign w_wr_led   = w_io_we & (w_off == OFF_LED);

    // Byte-lane bits are don't-care: every I/O register is a full word.
    assign w_unused_addr_lsb = ^cpu_addr[1:0];

    // DRAM sees address and data unconditionally; only the strobe is gated.
    assign dram_addr  = cpu_addr[ADDR_W+1:2];
    assign dram_wdata = cpu_wdata;
    assign dram_we    = cpu_we & ~w_io_sel;

    // -----------------------------------------------------------------------
    // Read path (combinational, zero latency)
    // -----------------------------------------------------------------------
    logic [31:0] w_io_rdata;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_io_rdata = 32'h0;
        case (w_off)
            OFF_SEG:   w_io_rdata = r_seg;
            OFF_TIMER: w_io_rdata = r_timer;
            OFF_LED:   w_io_rdata = {8'h0, r_led};
            OFF_SW:    w_io_rdata = {8'h0, r_sw_s2};
`ifdef SOC_BUS_BRIDGE_BTN_EN
            OFF_BTN:   w_io_rdata = {27'h0, r_btn_db};
`endif
            default:   w_io_rdata = 32'h0;
        endcase
    end

    assign cpu_rdata = w_io_sel ? w_io_rdata : dram_rdata;

    // -----------------------------------------------------------------------
    // CPU-writable registers and switch synchroniser
    // -----------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_seg   <= '0;
            r_led   <= '0;
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            if (w_wr_seg) r_seg <= cpu_wdata;
            if (w_wr_led) r_led <= cpu_wdata[23:0];
            r_sw_s1 <= sw_in;
            r_sw_s2 <= r_sw_s1;
        end
    end

    assign led_out = r_led;

    // -----------------------------------------------------------------------
    // Timer: a CPU write on the same edge as a prescaler wrap takes
    // priority and restarts the prescaler from zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_timer <= '0;
            r_tpre  <= '0;
        end else if (w_wr_timer) begin
            r_timer <= cpu_wdata;
            r_tpre  <= '0;
        end else if (r_tpre == TPRE_MAX) begin
            r_timer <= r_timer + 32'd1;
            r_tpre  <= '0;
        end else begin
            r_tpre  <= r_tpre + TPRE_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // 7-segment scan. The digit outputs are registered from the current
    // digit index and SEG contents, so they follow either one edge later.
    // -----------------------------------------------------------------------
    logic [3:0] w_nibble;

    assign w_nibble = r_seg[{r_digit, 2'b00} +: 4];

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_spre  <= '0;
            r_digit <= DIG0;
            r_an    <= 8'hFE;
            r_cx    <= 8'hC0;
        end else begin
            if (r_spre == SPRE_MAX) begin
                r_spre  <= '0;
                r_digit <= digit_t'(r_digit + 3'd1);
            end else begin
                r_spre  <= r_spre + SPRE_W'(1);
            end
            r_an <= ~(8'd1 << r_digit);
            r_cx <= hex_to_seg(w_nibble);
        end
    end

    assign seg_an = r_an;
    assign seg_cx = r_cx;

`ifdef SOC_BUS_BRIDGE_BTN_EN
    // -----------------------------------------------------------------------
    // Buttons: synchronise, then accept a new level only after it has been
    // held for SCAN_DIV consecutive cycles. Any bounce back to the accepted
    // level clears the run count.
    // -----------------------------------------------------------------------
    // NOTE: the per-bit counter array is cleared in reset like ordinary
    // flops; it is only five small counters, and a stale count would let a
    // button change be accepted early after reset.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_btn_db <= '0;
            for (int b = 0; b < 5; b++) r_btn_cnt[b] <= '0;
        end else begin
            r_btn_s1 <= btn_in;
            r_btn_s2 <= r_btn_s1;
            for (int b = 0; b < 5; b++) begin
                if (r_btn_s2[b] == r_btn_db[b]) begin
                    r_btn_cnt[b] <= '0;
                end else if (r_btn_cnt[b] == SPRE_MAX) begin
                    r_btn_db[b]  <= r_btn_s2[b];
                    r_btn_cnt[b] <= '0;
                end else begin
                    r_btn_cnt[b] <= r_btn_cnt[b] + SPRE_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_soc_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_soc_bus_bridge
//
// Directed bench for soc_bus_bridge with SCAN_DIV=4, TIMER_DIV=3.
// A behavioural model (cycle counters, a hex table, two-deep input history)
// tracks what every output must be; a compare process checks all outputs on
// every falling edge, and the stimulus adds hand-computed literal checks.
// Inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_soc_bus_bridge;

    localparam int ADDR_W    = 14;
    localparam int SCAN_DIV  = 4;
    localparam int TIMER_DIV = 3;

    localparam logic [31:0] A_SEG   = 32'hFFFF_F000;
    localparam logic [31:0] A_TIMER = 32'hFFFF_F020;
    localparam logic [31:0] A_LED   = 32'hFFFF_F060;
    localparam logic [31:0] A_SW    = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN   = 32'hFFFF_F078;

    localparam logic [7:0] HEX7 [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic              cpu_clk    = 1'b0;
    logic              cpu_rst    = 1'b0;
    logic [31:0]       cpu_addr   = '0;
    logic [31:0]       cpu_wdata  = '0;
    logic              cpu_we     = 1'b0;
    logic [31:0]       cpu_rdata;
    logic [ADDR_W-1:0] dram_addr;
    logic [31:0]       dram_wdata;
    logic              dram_we;
    logic [31:0]       dram_rdata = '0;
    logic [23:0]       sw_in      = '0;
`ifdef SOC_BUS_BRIDGE_BTN_EN
    logic [4:0]        btn_in     = '0;
`endif
    logic [23:0]       led_out;
    logic [7:0]        seg_an;
    logic [7:0]        seg_cx;

    always #5 cpu_clk = ~cpu_clk;

    soc_bus_bridge #(
        .ADDR_W    (ADDR_W),
        .SCAN_DIV  (SCAN_DIV),
        .TIMER_DIV (TIMER_DIV)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_rdata  (cpu_rdata),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_we    (dram_we),
        .dram_rdata (dram_rdata),
        .sw_in      (sw_in),
`ifdef SOC_BUS_BRIDGE_BTN_EN
        .btn_in     (btn_in),
`endif
        .led_out    (led_out),
        .seg_an     (seg_an),
        .seg_cx     (seg_cx)
    );

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------
    logic [31:0] m_seg      = '0;
    logic [31:0] m_timer    = '0;
    logic [23:0] m_led      = '0;
    logic [23:0] m_sw       = '0;   // switch value seen two edges ago
    logic [23:0] m_sw_prev  = '0;   // switch value seen one edge ago
    int          m_tph      = 0;    // cycles since last timer increment/load
    int          m_sph      = 0;    // cycles spent on the current digit
    int          m_d        = 0;    // digit being lit
    logic [7:0]  m_an       = 8'hFE;
    logic [7:0]  m_cx       = 8'hC0;
    logic        m_io;
    logic [11:0] m_off;
    logic        m_wr;
`ifdef SOC_BUS_BRIDGE_BTN_EN
    logic [4:0]  m_btn      = '0;
    logic [4:0]  m_btn_prev = '0;
    logic [4:0]  m_db       = '0;
    int          m_run [5]  = '{0, 0, 0, 0, 0};
`endif

    initial forever begin
        @(posedge cpu_clk or negedge cpu_rst);
        if (!cpu_rst) begin
            m_seg = '0; m_timer = '0; m_led = '0; m_sw = '0; m_sw_prev = '0;
            m_tph = 0;  m_sph = 0;    m_d = 0;
            m_an = 8'hFE; m_cx = 8'hC0;
`ifdef SOC_BUS_BRIDGE_BTN_EN
            m_btn = '0; m_btn_prev = '0; m_db = '0;
            for (int b = 0; b < 5; b++) m_run[b] = 0;
`endif
        end else begin
            // Display reflects the digit and SEG held before this edge.
            m_an  = ~(8'd1 << m_d);
            m_cx  = HEX7[m_seg[4*m_d +: 4]];
            m_io  = (cpu_addr[31:12] == 20'hFFFFF);
            m_off = {cpu_addr[11:2], 2'b00};
            m_wr  = cpu_we && m_io;
            if (m_wr && m_off == 12'h020) begin
                m_timer = cpu_wdata;
                m_tph   = 0;
            end else begin
                m_tph++;
                if (m_tph == TIMER_DIV) begin
                    m_tph = 0;
                    m_timer++;
                end
            end
            if (m_wr && m_off == 12'h000) m_seg = cpu_wdata;
            if (m_wr && m_off == 12'h060) m_led = cpu_wdata[23:0];
            m_sph++;
            if (m_sph == SCAN_DIV) begin
                m_sph = 0;
                m_d   = (m_d + 1) % 8;
            end
            m_sw      = m_sw_prev;
            m_sw_prev = sw_in;
`ifdef SOC_BUS_BRIDGE_BTN_EN
            for (int b = 0; b < 5; b++) begin
                if (m_btn[b] != m_db[b]) m_run[b]++;
                else m_run[b] = 0;
                if (m_run[b] == SCAN_DIV) begin
                    m_db[b]  = m_btn[b];
                    m_run[b] = 0;
                end
            end
            m_btn      = m_btn_prev;
            m_btn_prev = btn_in;
`endif
        end
    end

    function automatic logic [31:0] exp_rdata();
        logic [31:0] r;
        r = dram_rdata;
        if (cpu_addr[31:12] == 20'hFFFFF) begin
            case ({cpu_addr[11:2], 2'b00})
                12'h000: r = m_seg;
                12'h020: r = m_timer;
                12'h060: r = {8'h0, m_led};
                12'h070: r = {8'h0, m_sw};
`ifdef SOC_BUS_BRIDGE_BTN_EN
                12'h078: r = {27'h0, m_db};
`endif
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Compare process: every falling edge once enabled
    // -----------------------------------------------------------------------
    initial forever begin
        @(negedge cpu_clk);
        if (cmp_en) begin
            check("led_out",    32'(led_out),    32'(m_led));
            check("seg_an",     32'(seg_an),     32'(m_an));
            check("seg_cx",     32'(seg_cx),     32'(m_cx));
            check("dram_we",    32'(dram_we),    32'(cpu_we && cpu_addr[31:12] != 20'hFFFFF));
            check("dram_addr",  32'(dram_addr),  32'(cpu_addr[ADDR_W+1:2]));
            check("dram_wdata", dram_wdata,      cpu_wdata);
            check("cpu_rdata",  cpu_rdata,       exp_rdata());
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic peek();
        @(negedge cpu_clk);
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic we);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = we;
    endtask

    // Called just after a rising edge; returns just after a rising edge with
    // reset released, so the next edge is the first active one.
    task automatic do_reset();
        cpu_rst = 1'b0;
        ticks(2);
        cpu_rst = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    logic [7:0] an_exp [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    logic [7:0] cx_exp [9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'hC0};

    initial begin
        // Reset state, and combinational decode while held in reset.
        ticks(3);
        bus(A_TIMER, 32'h0, 1'b0);
        peek();
        check("rst_led",   32'(led_out), 32'h0);
        check("rst_an",    32'(seg_an),  32'hFE);
        check("rst_cx",    32'(seg_cx),  32'hC0);
        check("rst_timer", cpu_rdata,    32'h0);
        tick();
        bus(32'h0000_0010, 32'h1, 1'b1);
        #1 check("rst_dram_we", 32'(dram_we), 32'h1);
        bus(A_LED, 32'h1, 1'b1);
        #1 check("rst_io_we", 32'(dram_we), 32'h0);
        bus(A_TIMER, 32'h0, 1'b0);
        cmp_en = 1'b1;
        tick();
        cpu_rst = 1'b1;

        // Timer from reset release: 1 after three edges.
        tick(); tick();
        peek(); check("timer_2e", cpu_rdata, 32'h0);
        tick();
        peek(); check("timer_3e", cpu_rdata, 32'h1);
        // Load all-ones on the edge that would also tick (edge 6).
        tick(); tick();
        bus(A_TIMER, 32'hFFFF_FFFF, 1'b1);
        tick();
        bus(A_TIMER, 32'h0, 1'b0);
        peek(); check("timer_load", cpu_rdata, 32'hFFFF_FFFF);
        tick(); tick();
        peek(); check("timer_hold", cpu_rdata, 32'hFFFF_FFFF);
        tick();
        peek(); check("timer_wrap", cpu_rdata, 32'h0);

        // DRAM store vs LED store.
        tick();
        dram_rdata = 32'h1234_5678;
        bus(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        #1;
        check("dram_we_hit",  32'(dram_we),   32'h1);
        check("dram_addr_4",  32'(dram_addr), 32'h4);
        check("dram_rd_pass", cpu_rdata,      32'h1234_5678);
        tick();
        bus(A_LED, 32'hDEAD_BEEF, 1'b1);
        #1 check("led_no_dram", 32'(dram_we), 32'h0);
        tick();
        bus(A_LED, 32'h0, 1'b0);
        peek();
        check("led_out",  32'(led_out), 32'h00AD_BEEF);
        check("led_read", cpu_rdata,    32'h00AD_BEEF);
        tick();
        bus(A_LED | 32'h3, 32'h0, 1'b0);
        #1 check("led_read_lsb", cpu_rdata, 32'h00AD_BEEF);
        // Just below the I/O page still goes to DRAM.
        bus(32'hFFFF_EFFC, 32'h1, 1'b1);
        #1;
        check("edge_dram_we",   32'(dram_we),   32'h1);
        check("edge_dram_addr", 32'(dram_addr), 32'h3BFF);
        // Unmapped I/O write is dropped and reads zero.
        tick();
        bus(32'hFFFF_F044, 32'hCAFE_F00D, 1'b1);
        tick();
        bus(32'hFFFF_F044, 32'h0, 1'b0);
        peek(); check("unmapped", cpu_rdata, 32'h0);

        // Switch synchroniser: new value visible after exactly two edges.
        tick();
        sw_in = 24'h00A5A5;
        bus(A_SW, 32'h0, 1'b0);
        peek(); check("sw_0e", cpu_rdata, 32'h0);
        tick();
        peek(); check("sw_1e", cpu_rdata, 32'h0);
        tick();
        peek(); check("sw_2e", cpu_rdata, 32'h0000_A5A5);
        tick();
        bus(A_SW, 32'hFFFF_FFFF, 1'b1);
        tick();
        bus(A_SW, 32'h0, 1'b0);
        peek(); check("sw_ro", cpu_rdata, 32'h0000_A5A5);

        // Scan walk with SEG = 0x76543210.
        tick();
        do_reset();
        bus(A_SEG, 32'h7654_3210, 1'b1);
        tick();
        bus(A_SEG, 32'h0, 1'b0);
        tick();
        for (int k = 0; k < 9; k++) begin
            if (k > 0) ticks(SCAN_DIV);
            peek();
            check($sformatf("scan_an%0d", k), 32'(seg_an), 32'(an_exp[k]));
            check($sformatf("scan_cx%0d", k), 32'(seg_cx), 32'(cx_exp[k]));
        end
        check("seg_read", cpu_rdata, 32'h7654_3210);

        // Reset in the middle of digit 5 with TIMER = 7.
        tick();
        do_reset();
        bus(32'h0, 32'h0, 1'b0);
        ticks(19);
        bus(A_LED, 32'h0012_3456, 1'b1);
        tick();
        bus(A_TIMER, 32'h7, 1'b1);
        tick();
        bus(A_TIMER, 32'h0, 1'b0);
        #1;
        check("mid_an_d5",  32'(seg_an),  32'hDF);
        check("mid_timer7", cpu_rdata,    32'h7);
        check("mid_led",    32'(led_out), 32'h12_3456);
        cpu_rst = 1'b0;
        #1;
        check("mid_rst_an",    32'(seg_an),  32'hFE);
        check("mid_rst_cx",    32'(seg_cx),  32'hC0);
        check("mid_rst_led",   32'(led_out), 32'h0);
        check("mid_rst_timer", cpu_rdata,    32'h0);
        tick();
        cpu_rst = 1'b1;
        ticks(3);

`ifdef SOC_BUS_BRIDGE_BTN_EN
        // A 2-cycle pulse is rejected; a steady press is accepted.
        tick();
        bus(A_BTN, 32'h0, 1'b0);
        btn_in = 5'b00001;
        ticks(2);
        btn_in = 5'b00000;
        ticks(8);
        peek(); check("btn_pulse", cpu_rdata, 32'h0);
        tick();
        btn_in = 5'b10001;
        ticks(10);
        peek(); check("btn_held", cpu_rdata, 32'h11);
`else
        tick();
        bus(A_BTN, 32'h0, 1'b0);
        peek(); check("btn_unmapped", cpu_rdata, 32'h0);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net: the sequence is a few hundred cycles.
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
